// File: rtl/windowed_register_file.sv
// windowed_register_file: 2R/1W physical register file with write-first forwarding
// and a post-reset zero-fill sequencer, so the array itself carries no reset.
`default_nettype none

module windowed_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] r_addr_a,
    input  logic [ADDR_WIDTH-1:0] r_addr_b,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data_a,
    output logic [DATA_WIDTH-1:0] r_data_b,
    output logic                  init_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   r_data_a_q, r_data_a_d;
    logic [DATA_WIDTH-1:0]   r_data_b_q, r_data_b_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_data_a_d = '0;
        r_data_b_d = '0;
        mem_we     = 1'b0;
        mem_wa     = cnt_q;
        mem_wd     = '0;
        case (state_q)
            INIT: begin
                // Counter wraps to 0 on the terminal edge but the state leaves INIT,
                // so no second fill can start.
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                mem_we     = w_en;
                mem_wa     = w_addr;
                mem_wd     = w_data;
                r_data_a_d = (w_en && (w_addr == r_addr_a)) ? w_data : mem_q[r_addr_a];
                r_data_b_d = (w_en && (w_addr == r_addr_b)) ? w_data : mem_q[r_addr_b];
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            r_data_a_q <= '0;
            r_data_b_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_data_a_q <= r_data_a_d;
            r_data_b_q <= r_data_b_d;
        end
    end

    // Storage has no reset; the fill sequence clears it after every reset.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign r_data_a  = r_data_a_q;
    assign r_data_b  = r_data_b_q;
    assign init_busy = (state_q == INIT);

endmodule

`default_nettype wire

// File: tb/tb_windowed_register_file.sv
// tb_windowed_register_file: table vectors, multi-cycle init/reset sequences and
// randomized traffic checked against an array model of the register file.
`default_nettype none

module tb_windowed_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  r_addr_a, r_addr_b, w_addr;
    logic        w_en;
    logic [15:0] w_data;
    logic [15:0] r_data_a, r_data_b;
    logic        init_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] ref_mem [128];

    typedef struct {
        logic        we;
        logic [6:0]  wa;
        logic [15:0] wd;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vec [12];

    windowed_register_file dut (
        .clk      (clk),
        .reset    (reset),
        .r_addr_a (r_addr_a),
        .r_addr_b (r_addr_b),
        .w_addr   (w_addr),
        .w_en     (w_en),
        .w_data   (w_data),
        .r_data_a (r_data_a),
        .r_data_b (r_data_b),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [6:0] wa, input logic [15:0] wd,
                         input logic [6:0] ra, input logic [6:0] rb);
        w_en = we; w_addr = wa; w_data = wd; r_addr_a = ra; r_addr_b = rb;
    endtask

    // Counts edges with init_busy high after reset release; optionally injects a
    // write at fill cycle 2 and an early reset pulse at fill cycle abort_at.
    task automatic run_init(input bit poke_write, input int abort_at, output int edges);
        int n;
        n = 0;
        reset = 1'b0;
        drive(1'b0, 7'd0, 16'd0, 7'd0, 7'd127);
        while (n < 300) begin
            if (poke_write && n == 1) drive(1'b1, 7'h05, 16'hFFFF, 7'h05, 7'h05);
            else drive(1'b0, 7'd0, 16'd0, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            if (abort_at > 0 && n == abort_at) reset = 1'b1;
            step();
            if (reset) begin
                chk("reset_pulse_busy", 32'(init_busy), 32'd1);
                reset = 1'b0;
                n = 0;
                abort_at = 0;
                continue;
            end
            n++;
            if (!init_busy) break;
            if (r_data_a !== 16'd0 || r_data_b !== 16'd0)
                chk("init_rdata_zero", {r_data_a, r_data_b}, 32'd0);
        end
        edges = n;
        w_en = 1'b0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 16'd0;
    endtask

    initial begin
        int edges;
        logic [15:0] ea, eb;

        vec[0]  = '{1'b0, 7'h00, 16'h0000, 7'h00, 7'h40, 16'h0000, 16'h0000};
        vec[1]  = '{1'b0, 7'h00, 16'h0000, 7'h7F, 7'h05, 16'h0000, 16'h0000};
        vec[2]  = '{1'b1, 7'h12, 16'hA5A5, 7'h00, 7'h01, 16'h0000, 16'h0000};
        vec[3]  = '{1'b1, 7'h7F, 16'h5A5A, 7'h12, 7'h00, 16'hA5A5, 16'h0000};
        vec[4]  = '{1'b0, 7'h00, 16'h0000, 7'h12, 7'h7F, 16'hA5A5, 16'h5A5A};
        vec[5]  = '{1'b1, 7'h30, 16'h0001, 7'h00, 7'h00, 16'h0000, 16'h0000};
        vec[6]  = '{1'b1, 7'h30, 16'h1234, 7'h30, 7'h30, 16'h1234, 16'h1234};
        vec[7]  = '{1'b0, 7'h00, 16'h0000, 7'h30, 7'h12, 16'h1234, 16'hA5A5};
        // Logical r3 seen through windows 1 and 2 maps to distinct physical entries.
        vec[8]  = '{1'b1, 7'h13, 16'h1111, 7'h23, 7'h00, 16'h0000, 16'h0000};
        vec[9]  = '{1'b1, 7'h23, 16'h2222, 7'h13, 7'h23, 16'h1111, 16'h2222};
        vec[10] = '{1'b0, 7'h00, 16'h0000, 7'h23, 7'h13, 16'h2222, 16'h1111};
        vec[11] = '{1'b1, 7'h40, 16'hBEEF, 7'h40, 7'h7F, 16'hBEEF, 16'h5A5A};

        reset = 1'b1;
        drive(1'b1, 7'h10, 16'hDEAD, 7'h10, 7'h10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_rdata_a", 32'(r_data_a), 32'd0);
            chk("reset_rdata_b", 32'(r_data_b), 32'd0);
            chk("reset_busy", 32'(init_busy), 32'd1);
        end

        run_init(1'b1, 0, edges);
        chk("init_length", 32'(edges), 32'd128);
        chk("busy_low_after_init", 32'(init_busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].we, vec[i].wa, vec[i].wd, vec[i].ra, vec[i].rb);
            step();
            if (vec[i].we) ref_mem[vec[i].wa] = vec[i].wd;
            chk($sformatf("vec%0d_a", i), 32'(r_data_a), 32'(vec[i].exp_a));
            chk($sformatf("vec%0d_b", i), 32'(r_data_b), 32'(vec[i].exp_b));
        end
        w_en = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic       we;
            logic [6:0] wa, ra, rb;
            logic [15:0] wd;
            we = 1'($urandom);
            wa = 7'($urandom_range(0, 127));
            wd = 16'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 7'($urandom_range(0, 127));
            rb = ($urandom_range(0, 3) == 0) ? ra : 7'($urandom_range(0, 127));
            if (i % 16 < 8) begin
                wa = wa & 7'h07; ra = ra & 7'h07; rb = rb & 7'h07;
            end
            drive(we, wa, wd, ra, rb);
            ea = (we && wa == ra) ? wd : ref_mem[ra];
            eb = (we && wa == rb) ? wd : ref_mem[rb];
            step();
            if (we) ref_mem[wa] = wd;
            if (r_data_a !== ea) chk("rand_a", 32'(r_data_a), 32'(ea));
            else n_cmp++;
            if (r_data_b !== eb) chk("rand_b", 32'(r_data_b), 32'(eb));
            else n_cmp++;
            chk("rand_busy", 32'(init_busy), 32'd0);
        end

        drive(1'b1, 7'h40, 16'hBEEF, 7'h00, 7'h00);
        step();
        w_en = 1'b0;
        reset = 1'b1;
        step();
        chk("midop_reset_busy", 32'(init_busy), 32'd1);
        chk("midop_reset_rdata", 32'(r_data_a), 32'd0);
        run_init(1'b0, 50, edges);
        chk("reinit_length", 32'(edges), 32'd128);
        drive(1'b0, 7'h00, 16'h0000, 7'h40, 7'h12);
        step();
        chk("reinit_0x40_a", 32'(r_data_a), 32'd0);
        chk("reinit_0x12_b", 32'(r_data_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
